// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed 16-lane FFT output beats into a natural-order, one-sample-per-cycle stream.
// Two ping-pong banks hold whole frames; frames arriving with no free bank are dropped and flagged.
module fft_out_reorder #(
    parameter int D_WIDTH     = 15,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAME_BEATS = 32,
    parameter int LOG2N       = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic signed [D_WIDTH-1:0] din_re [0:DATA_WIDTH-1],
    input  logic signed [D_WIDTH-1:0] din_im [0:DATA_WIDTH-1],
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic signed [D_WIDTH-1:0] dout_re,
    output logic signed [D_WIDTH-1:0] dout_im,
    output logic [LOG2N-1:0]          dout_index,
    output logic                      dout_last,
    output logic                      overflow
);
    localparam int N      = DATA_WIDTH * FRAME_BEATS;
    localparam int LANE_W = $clog2(DATA_WIDTH);
    localparam int BEAT_W = $clog2(FRAME_BEATS);
    localparam int ADDR_W = BEAT_W + 1;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] y;
        for (int i = 0; i < LOG2N; i++) begin
            y[i] = x[LOG2N-1-i];
        end
        return y;
    endfunction

    // Lane-sliced storage: each lane memory holds one word per beat for both banks.
    logic signed [D_WIDTH-1:0] r_mem_re [0:DATA_WIDTH-1][0:2*FRAME_BEATS-1];
    logic signed [D_WIDTH-1:0] r_mem_im [0:DATA_WIDTH-1][0:2*FRAME_BEATS-1];

    bank_t                     r_bank [0:1];
    logic [BEAT_W-1:0]         r_beat;
    logic                      r_wr_bank;
    logic                      r_wr_active;
    logic                      r_overflow;

    rd_state_t                 r_rd_state;
    logic                      r_rd_bank;
    logic [LOG2N-1:0]          r_rd_cnt;
    logic                      r_rd_done;

    logic                      r_dout_valid;
    logic signed [D_WIDTH-1:0] r_dout_re;
    logic signed [D_WIDTH-1:0] r_dout_im;
    logic [LOG2N-1:0]          r_dout_index;
    logic                      r_dout_last;

    logic                      w_beat_first;
    logic                      w_beat_last;
    logic                      w_claim;
    logic                      w_drop;
    logic                      w_wr_en;
    logic                      w_fill_done;
    logic                      w_hs;
    logic                      w_hs_last;
    logic                      w_start;
    logic                      w_swap;
    logic                      w_ld;
    logic                      w_ld_bank;
    logic [LOG2N-1:0]          w_ld_cnt;
    logic [LOG2N-1:0]          w_ld_pos;
    logic [LANE_W-1:0]         w_ld_lane;
    logic [BEAT_W-1:0]         w_ld_beat;
    logic [ADDR_W-1:0]         w_ld_addr;
    logic [ADDR_W-1:0]         w_wr_addr;

    assign w_beat_first = din_valid && (r_beat == '0);
    assign w_beat_last  = din_valid && (r_beat == BEAT_W'(FRAME_BEATS - 1));

    assign w_hs      = r_dout_valid && dout_ready;
    assign w_hs_last = w_hs && r_dout_last;

    // A bank whose final sample is handed off this cycle is already free for a new frame.
    assign w_claim = w_beat_first &&
                     ((r_bank[r_wr_bank] == B_EMPTY) || (w_hs_last && (r_rd_bank == r_wr_bank)));
    assign w_drop  = w_beat_first && !w_claim;

    assign w_wr_en     = din_valid && (w_beat_first ? w_claim : r_wr_active);
    assign w_fill_done = w_wr_en && w_beat_last;
    assign w_wr_addr   = {r_wr_bank, r_beat};

    assign w_start = (r_rd_state == R_IDLE) && (r_bank[r_rd_bank] == B_FULL);
    assign w_swap  = w_hs_last && (r_bank[!r_rd_bank] == B_FULL);

    // On the last handshake of a bank, the next load comes from sample 0 of the other bank.
    assign w_ld_bank = w_hs_last ? !r_rd_bank : r_rd_bank;
    assign w_ld_cnt  = w_hs_last ? '0 : r_rd_cnt;
    assign w_ld      = (r_rd_state == R_DRAIN) && (!r_dout_valid || dout_ready) &&
                       (w_hs_last ? w_swap : !r_rd_done);

    assign w_ld_pos  = bitrev(w_ld_cnt);
    assign w_ld_lane = w_ld_pos[LANE_W-1:0];
    assign w_ld_beat = w_ld_pos[LOG2N-1:LANE_W];
    assign w_ld_addr = {w_ld_bank, w_ld_beat};

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int l = 0; l < DATA_WIDTH; l++) begin
                r_mem_re[l][w_wr_addr] <= din_re[l];
                r_mem_im[l][w_wr_addr] <= din_im[l];
            end
        end
    end

    // Beat counting runs through dropped frames so frame alignment survives an overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat      <= '0;
            r_wr_bank   <= 1'b0;
            r_wr_active <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (din_valid) begin
            r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
            if (w_beat_first) begin
                r_wr_active <= w_claim;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_fill_done) begin
                r_wr_bank <= !r_wr_bank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank[0] <= B_EMPTY;
            r_bank[1] <= B_EMPTY;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_claim && (r_wr_bank == 1'(k))) begin
                    r_bank[k] <= B_FILLING;
                end else if (w_fill_done && (r_wr_bank == 1'(k))) begin
                    r_bank[k] <= B_FULL;
                end else if ((w_start && (r_rd_bank == 1'(k))) ||
                             (w_swap && (r_rd_bank != 1'(k)))) begin
                    r_bank[k] <= B_DRAINING;
                end else if (w_hs_last && (r_rd_bank == 1'(k))) begin
                    r_bank[k] <= B_EMPTY;
                end
            end
        end
    end

    // The output register doubles as the memory read register, so a stall simply skips the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state   <= R_IDLE;
            r_rd_bank    <= 1'b0;
            r_rd_cnt     <= '0;
            r_rd_done    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_re    <= '0;
            r_dout_im    <= '0;
            r_dout_index <= '0;
            r_dout_last  <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_start) begin
                        r_rd_state <= R_DRAIN;
                        r_rd_cnt   <= '0;
                        r_rd_done  <= 1'b0;
                    end
                end
                R_DRAIN: begin
                    if (w_hs_last) begin
                        r_rd_bank  <= !r_rd_bank;
                        r_rd_state <= w_swap ? R_DRAIN : R_IDLE;
                        r_rd_cnt   <= '0;
                        r_rd_done  <= 1'b0;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase

            if (w_ld) begin
                r_dout_valid <= 1'b1;
                r_dout_re    <= r_mem_re[w_ld_lane][w_ld_addr];
                r_dout_im    <= r_mem_im[w_ld_lane][w_ld_addr];
                r_dout_index <= w_ld_cnt;
                r_dout_last  <= (w_ld_cnt == LOG2N'(N - 1));
                r_rd_cnt     <= w_ld_cnt + 1'b1;
                r_rd_done    <= (w_ld_cnt == LOG2N'(N - 1));
            end else if (w_hs) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_re    = r_dout_re;
    assign dout_im    = r_dout_im;
    assign dout_index = r_dout_index;
    assign dout_last  = r_dout_last;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: expected natural-order samples are queued as frames are
// driven and checked, together with stall stability, on every output handshake.
`timescale 1ns/1ps
module tb_fft_out_reorder;
    localparam int D_WIDTH     = 15;
    localparam int DATA_WIDTH  = 16;
    localparam int FRAME_BEATS = 32;
    localparam int LOG2N       = 9;
    localparam int N           = DATA_WIDTH * FRAME_BEATS;

    typedef struct packed {
        logic signed [D_WIDTH-1:0] re;
        logic signed [D_WIDTH-1:0] im;
        logic [LOG2N-1:0]          idx;
    } samp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_valid = 1'b0;
    logic dout_ready = 1'b0;
    logic signed [D_WIDTH-1:0] din_re [0:DATA_WIDTH-1];
    logic signed [D_WIDTH-1:0] din_im [0:DATA_WIDTH-1];
    logic                      dout_valid;
    logic signed [D_WIDTH-1:0] dout_re;
    logic signed [D_WIDTH-1:0] dout_im;
    logic [LOG2N-1:0]          dout_index;
    logic                      dout_last;
    logic                      overflow;

    fft_out_reorder #(
        .D_WIDTH(D_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .FRAME_BEATS(FRAME_BEATS), .LOG2N(LOG2N)
    ) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_re(dout_re), .dout_im(dout_im),
        .dout_index(dout_index), .dout_last(dout_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    samp_t exp_q[$];
    logic signed [D_WIDTH-1:0] fr_re [0:N-1];
    logic signed [D_WIDTH-1:0] fr_im [0:N-1];

    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [39:0] hold_vec = '0;
    int          n_out = 0;
    longint      cyc = 0;
    logic signed [D_WIDTH-1:0] obs_re  [0:2047];
    logic signed [D_WIDTH-1:0] obs_im  [0:2047];
    logic [LOG2N-1:0]          obs_idx [0:2047];
    logic                      obs_last[0:2047];
    longint                    obs_cyc [0:2047];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bitrev_n(input int x);
        int y;
        y = 0;
        for (int i = 0; i < LOG2N; i++) begin
            if ((x >> i) & 1) y = y | (1 << (LOG2N - 1 - i));
        end
        return y;
    endfunction

    // Scoreboard: every handshake pops one expected sample; stalled outputs must not move.
    always @(negedge clk) begin
        samp_t       e;
        logic [39:0] act;
        logic [39:0] req;
        if (mon_en) begin
            act = {dout_re, dout_im, dout_index, dout_last};
            if (stall_prev) begin
                n_tests++;
                if (act !== hold_vec) begin
                    n_fail++;
                    $display("FAIL hold_stable got %h required %h", act, hold_vec);
                end
            end
            if (dout_valid && dout_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_sample got re=%0d idx=%0d required no sample", dout_re, dout_index);
                end else begin
                    e   = exp_q.pop_front();
                    req = {e.re, e.im, e.idx, (e.idx == LOG2N'(N - 1))};
                    if (act !== req) begin
                        n_fail++;
                        $display("FAIL sample[%0d] got re=%0d im=%0d idx=%0d last=%0b required re=%0d im=%0d idx=%0d last=%0b",
                                 n_out, dout_re, dout_im, dout_index, dout_last,
                                 e.re, e.im, e.idx, req[0]);
                    end
                    if (n_out < 2048) begin
                        obs_re[n_out]   = dout_re;
                        obs_im[n_out]   = dout_im;
                        obs_idx[n_out]  = dout_index;
                        obs_last[n_out] = dout_last;
                        obs_cyc[n_out]  = cyc;
                    end
                    n_out++;
                end
            end
            stall_prev = dout_valid && !dout_ready;
            hold_vec   = act;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // mode 0: re=p, im=-p; mode 1: tagged ramp; mode 2: random
    task automatic make_frame(input int mode, input int tag);
        for (int p = 0; p < N; p++) begin
            case (mode)
                0: begin fr_re[p] = D_WIDTH'(p); fr_im[p] = D_WIDTH'(-p); end
                1: begin fr_re[p] = D_WIDTH'(tag * 600 + p); fr_im[p] = D_WIDTH'(tag * 100 - 3 * p); end
                default: begin fr_re[p] = D_WIDTH'($urandom); fr_im[p] = D_WIDTH'($urandom); end
            endcase
        end
    endtask

    task automatic push_frame();
        samp_t s;
        for (int n = 0; n < N; n++) begin
            s.re  = fr_re[bitrev_n(n)];
            s.im  = fr_im[bitrev_n(n)];
            s.idx = LOG2N'(n);
            exp_q.push_back(s);
        end
    endtask

    task automatic drive_beats(input int first, input int stop);
        for (int b = first; b < stop; b++) begin
            for (int l = 0; l < DATA_WIDTH; l++) begin
                din_re[l] = fr_re[b * DATA_WIDTH + l];
                din_im[l] = fr_im[b * DATA_WIDTH + l];
            end
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic apply_reset();
        mon_en    = 1'b0;
        din_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int l = 0; l < DATA_WIDTH; l++) begin din_re[l] = '0; din_im[l] = '0; end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b required 0", dout_valid); end
        n_tests++; if (dout_re !== '0) begin n_fail++; $display("FAIL rst_re got %0d required 0", dout_re); end
        n_tests++; if (dout_im !== '0) begin n_fail++; $display("FAIL rst_im got %0d required 0", dout_im); end
        n_tests++; if (dout_index !== '0) begin n_fail++; $display("FAIL rst_index got %0d required 0", dout_index); end
        n_tests++; if (dout_last !== 1'b0) begin n_fail++; $display("FAIL rst_last got %0b required 0", dout_last); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %0b required 0", overflow); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %0b required 0", dout_valid); end
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_single_frame();
        dout_ready = 1'b1;
        n_out = 0;
        make_frame(0, 0);
        push_frame();
        drive_beats(0, FRAME_BEATS);
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e0 got %0b required 0", dout_valid); end
        @(posedge clk); #1;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL latency_e1 got %0b required 0", dout_valid); end
        @(posedge clk); #1;
        n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL latency_e2 got %0b required 1", dout_valid); end
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain remaining %0d required 0", exp_q.size()); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (n_out != N) begin n_fail++; $display("FAIL single_count got %0d required %0d", n_out, N); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_end_valid got %0b required 0", dout_valid); end
        n_tests++; if (obs_re[0] !== 15'sd0) begin n_fail++; $display("FAIL bin0_re got %0d required 0", obs_re[0]); end
        n_tests++; if (obs_re[1] !== 15'sd256) begin n_fail++; $display("FAIL bin1_re got %0d required 256", obs_re[1]); end
        n_tests++; if (obs_im[1] !== -15'sd256) begin n_fail++; $display("FAIL bin1_im got %0d required -256", obs_im[1]); end
        n_tests++; if (obs_re[2] !== 15'sd128) begin n_fail++; $display("FAIL bin2_re got %0d required 128", obs_re[2]); end
        n_tests++; if (obs_re[511] !== 15'sd511) begin n_fail++; $display("FAIL bin511_re got %0d required 511", obs_re[511]); end
        n_tests++; if (obs_last[511] !== 1'b1) begin n_fail++; $display("FAIL bin511_last got %0b required 1", obs_last[511]); end
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b1;
        n_out = 0;
        make_frame(1, 1); push_frame(); drive_beats(0, FRAME_BEATS);
        make_frame(1, 2); push_frame(); drive_beats(0, FRAME_BEATS);
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain remaining %0d required 0", exp_q.size()); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (n_out != 2 * N) begin n_fail++; $display("FAIL b2b_count got %0d required %0d", n_out, 2 * N); end
        n_tests++; if (obs_cyc[1023] - obs_cyc[0] != 1023) begin n_fail++; $display("FAIL b2b_contiguous got span %0d required 1023", obs_cyc[1023] - obs_cyc[0]); end
        n_tests++; if (obs_idx[511] !== 9'd511 || obs_idx[512] !== 9'd0) begin n_fail++; $display("FAIL b2b_index_wrap got %0d,%0d required 511,0", obs_idx[511], obs_idx[512]); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %0b required 0", overflow); end
    endtask

    task automatic test_overflow();
        dout_ready = 1'b0;
        n_out = 0;
        make_frame(1, 3); push_frame(); drive_beats(0, FRAME_BEATS);
        make_frame(1, 4); push_frame(); drive_beats(0, FRAME_BEATS);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %0b required 0", overflow); end
        make_frame(1, 5); drive_beats(0, FRAME_BEATS);
        repeat (10) @(posedge clk);
        #1;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b required 1", overflow); end
        n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_stalled_valid got %0b required 1", dout_valid); end
        dout_ready = 1'b1;
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain remaining %0d required 0", exp_q.size()); end
        repeat (40) @(posedge clk);
        #1;
        n_tests++; if (n_out != 2 * N) begin n_fail++; $display("FAIL ovf_count got %0d required %0d", n_out, 2 * N); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_end_valid got %0b required 0", dout_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b required 1", overflow); end
        apply_reset();
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %0b required 0", overflow); end
    endtask

    task automatic test_random_ready();
        n_out = 0;
        make_frame(2, 0);
        push_frame();
        fork
            drive_beats(0, FRAME_BEATS);
            begin
                for (int c = 0; c < 4000 && (exp_q.size() != 0 || c < 40); c++) begin
                    @(posedge clk); #1;
                    dout_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_ready = 1'b1;
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain remaining %0d required 0", exp_q.size()); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (n_out != N) begin n_fail++; $display("FAIL rand_count got %0d required %0d", n_out, N); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rand_end_valid got %0b required 0", dout_valid); end
    endtask

    task automatic test_coincident_free();
        bit found;
        dout_ready = 1'b1;
        n_out = 0;
        make_frame(1, 6); push_frame(); drive_beats(0, FRAME_BEATS);
        make_frame(1, 7); push_frame(); drive_beats(0, FRAME_BEATS);
        make_frame(1, 8); push_frame();
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (dout_valid && dout_ready && dout_last) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL coincide_last_seen got 0 required 1"); end
        drive_beats(0, FRAME_BEATS);
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL coincide_drain remaining %0d required 0", exp_q.size()); end
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (n_out != 3 * N) begin n_fail++; $display("FAIL coincide_count got %0d required %0d", n_out, 3 * N); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL coincide_overflow got %0b required 0", overflow); end
    endtask

    task automatic test_reset_midframe();
        dout_ready = 1'b1;
        n_out = 0;
        make_frame(1, 9); push_frame(); drive_beats(0, FRAME_BEATS);
        make_frame(1, 10); drive_beats(0, 17);
        n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL mid_draining got %0b required 1", dout_valid); end
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        n_tests++; if (dout_valid !== 1'b0 || dout_re !== '0 || dout_im !== '0 || dout_index !== '0 || dout_last !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got v=%0b re=%0d im=%0d idx=%0d last=%0b ovf=%0b required all 0",
                     dout_valid, dout_re, dout_im, dout_index, dout_last, overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        n_out = 0;
        @(negedge clk);
        mon_en = 1'b1;
        @(posedge clk); #1;
        make_frame(1, 11); push_frame(); drive_beats(0, FRAME_BEATS);
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_drain remaining %0d required 0", exp_q.size()); end
        repeat (40) @(posedge clk);
        #1;
        n_tests++; if (n_out != N) begin n_fail++; $display("FAIL mid_count got %0d required %0d", n_out, N); end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_end_valid got %0b required 0", dout_valid); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_random_ready();
        test_coincident_free();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
Output-side consumer of the parallel FFT pipeline. It accepts one 16-lane vector per beat, in bit-reversed arrival order, from the final butterfly/twiddle stage. It buffers whole frames in a two-bank ping-pong memory and streams the frame out one complex sample per cycle, in natural order, over a valid/ready interface. The FFT pipeline cannot stall, so the input has no backpressure, and frames that cannot be buffered are dropped and flagged.

Parameters:
D_WIDTH, 15, bit width of each real/imag sample (signed), in and out
DATA_WIDTH, 16, lanes per input beat
FRAME_BEATS, 32, input beats per frame; N = DATA_WIDTH*FRAME_BEATS = 512 points
LOG2N, 9, log2(N); must match DATA_WIDTH*FRAME_BEATS

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
din_valid  in  1  input beat strobe; no ready, so the beat is taken or dropped
din_re  in  D_WIDTH x [0:DATA_WIDTH-1]  signed real lanes
din_im  in  D_WIDTH x [0:DATA_WIDTH-1]  signed imag lanes
dout_valid  out  1  output sample valid
dout_ready  in  1  downstream accepts sample
dout_re  out  D_WIDTH  signed real sample
dout_im  out  D_WIDTH  signed imag sample
dout_index  out  LOG2N  natural-order bin index of the current sample
dout_last  out  1  high with bin N-1
overflow  out  1  sticky frame-drop flag

Behaviour:
- Reset (async, rst=1):
  - dout_valid, dout_re, dout_im, dout_index, dout_last and overflow all go to 0.
  - Both banks go to EMPTY; beat counter, read counter and bank pointers go to 0.
  - Reset mid-frame discards all buffered data. After reset deasserts, the first din_valid beat is beat 0 of a new frame.
- Arrival order:
  - Beat b (0..FRAME_BEATS-1), lane l carries arrival position p = b*DATA_WIDTH + l.
  - That sample's natural bin index is n = bitrev_LOG2N(p).
  - Output emits n = 0..N-1 in order, reading stored position bitrev_LOG2N(n).
- Beat counter:
  - Increments on every din_valid beat and wraps FRAME_BEATS-1 -> 0.
  - It also counts during dropped frames, so frame alignment is kept.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - At beat 0, the writer claims the EMPTY bank pointed to by wr_bank; wr_bank toggles after the last beat.
  - If no bank is EMPTY at beat 0, the whole frame (all FRAME_BEATS beats) is ignored and overflow is set to 1. overflow clears only on reset.
- Writer:
  - The last beat moves the bank FILLING -> FULL.
  - A FULL bank becomes claimable again only after it has been fully drained.
- Reader FSM, states R_IDLE and R_DRAIN:
  - R_IDLE -> R_DRAIN when the bank at rd_bank is FULL.
  - In R_DRAIN, the output advances on each dout_valid & dout_ready handshake.
  - When the handshake on n=N-1 completes: the bank goes to EMPTY, rd_bank toggles, and the FSM goes to R_DRAIN again if the other bank is FULL, otherwise R_IDLE.
- Latency and throughput:
  - dout_valid first rises 2 cycles after the clock edge that captures the last beat of a frame (bank in R_IDLE case).
  - With dout_ready held at 1, one sample is emitted per cycle with no bubbles, including back-to-back frames across the bank swap.
  - Memory is read synchronously, so the implementation prefetches or uses a skid register to meet this.
- Output hold rule: while dout_valid=1 and dout_ready=0, dout_re, dout_im, dout_index and dout_last hold stable.
- Widths: data passes through bit-exact, with no scaling or rounding.
- Simultaneous events:
  - A write into one bank and a drain of the other bank in the same cycle is legal.
  - Beat 0 arriving in the same cycle as the final drain handshake of the only non-EMPTY bank counts as EMPTY available: the bank is freed first, so the frame is not dropped.

Test Plan:
- Single frame, lane data re=p, im=-p, dout_ready=1 -> dout_valid rises 2 cycles after beat 31. Outputs in order: n=0 re=0; n=1 re=256, im=-256; n=2 re=128; n=511 re=511 with dout_last=1. Exactly 512 samples, then dout_valid=0.
- Two frames back-to-back (64 consecutive beats), dout_ready=1 -> 1024 contiguous samples with no gap at the swap. dout_index wraps 511 -> 0. overflow stays 0.
- Three consecutive frames with dout_ready=0 -> frames 1 and 2 buffered, frame 3 dropped, overflow=1. Then raise ready -> exactly 1024 samples (frames 1 and 2), and frame 3's data never appears.
- Random dout_ready (about 50% duty) over one frame -> output values stay stable while stalled, the sequence matches the golden bit-reverse model, and no sample is duplicated or lost.
- Beat 0 of frame 3 coinciding with the final drain handshake (n=511) of frame 1 while frame 2 is FULL -> frame 3 is accepted and overflow stays 0.
- rst=1 for 1 cycle at beat 17 of a frame while another frame is draining -> all outputs are 0 immediately. After release, a fresh frame streams out correctly with no stale data.
